mc_datapath: RTL
================

# mc_datapath

Multi-cycle MIPS-subset core that succeeds the single-cycle datapath: one instruction is executed over 3–5 FSM states sharing one ALU and one memory port. The controller FSM is integrated. Instruction and data traffic use a single external memory bus with a ready handshake, so wait-state memories and the existing `im_4k`/`dm_4k` behind an arbiter are both supported. It sits at the top of the CPU hierarchy.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000: PC value loaded on reset.
- `ADDR_W`, 32: width of `mem_addr`, taken from the low bits of the byte address.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `mem_req`, output, 1: memory access request.
- `mem_we`, output, 1: write enable, valid when `mem_req` is high.
- `mem_addr`, output, ADDR_W: byte address, word aligned (bits [1:0] = 0).
- `mem_wdata`, output, 32: store data.
- `mem_rdata`, input, 32: load/fetch data, valid when `mem_ready` is high.
- `mem_ready`, input, 1: access completes in this cycle.
- `pc`, output, 32: current PC.
- `instruction`, output, 32: instruction register (IR).
- `retire`, output, 1: one-cycle pulse in the last cycle of each instruction.
- `halt`, output, 1: high once an unsupported instruction is decoded.
- `wb_en`, `wb_addr`[4:0], `wb_data`[31:0], outputs: register-file write port, exposed for checking.

## Operation
- Supported instructions:
  - R-type: addu (funct 0x21), subu (0x23), jr (0x08).
  - I-type: ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04.
  - J-type: j 0x02, jal 0x03.
- Internal registers: PC, IR, A, B, ALUOut, MDR.
- FETCH:
  - Drive `mem_req`=1, `mem_we`=0, `mem_addr`=PC.
  - When `mem_ready`=1: IR←`mem_rdata`, PC←PC+4, go to DECODE. Otherwise stay.
- DECODE:
  - A←rs, B←rt.
  - ALUOut←PC+(sext(imm)<<2), which is the branch target.
  - Unsupported opcode/funct → HALT.
  - j: PC←{PC[31:28],target,2'b00}, then FETCH. jal also writes $31←PC (already +4).
- EXEC:
  - R-type: ALUOut←A op B, go to RWB.
  - ori: ALUOut←A|zext(imm). lui: ALUOut←{imm,16'h0}. Both go to RWB.
  - lw/sw: ALUOut←A+sext(imm), go to MEM.
  - beq: if A==B then PC←ALUOut. Then FETCH.
  - jr: PC←A, then FETCH.
- MEM:
  - Request at ALUOut. sw drives `mem_we`=1, `mem_wdata`=B.
  - On `mem_ready`: sw → FETCH; lw → MDR←`mem_rdata`, go to MWB.
- RWB / MWB:
  - Write rd (R-type) or rt (I-type) with ALUOut (RWB) or MDR (MWB).
  - Then FETCH.
- HALT: absorbing. No requests, `halt`=1. Only reset exits.
- Writes to $0 are dropped: `wb_en` is still asserted, but $0 reads as 0.
- Arithmetic is modulo 2^32. No overflow traps.
- `retire` is asserted in:
  - the final state of every instruction (j/jal DECODE, beq/jr EXEC, sw MEM completion cycle, RWB, MWB);
  - the cycle HALT is entered (unsupported instruction retires with no effect).

## Timing
- Reset values:
  - PC=RESET_PC, state=FETCH.
  - IR, A, B, ALUOut, MDR and all registers = 0.
  - All outputs 0 except `pc`.
  - `mem_req` falls asynchronously with `rst`.
- Zero-wait-state cycle counts: j/jal 2, beq/jr 3, sw/R-type/ori/lui 4, lw 5.
- Each cycle `mem_ready` is low in FETCH or MEM adds exactly one cycle.
- Handshake:
  - `mem_req`, `mem_addr`, `mem_we` and `mem_wdata` are held stable until the cycle `mem_ready`=1.
  - `mem_req` may drop the following cycle.
  - `mem_ready` while `mem_req`=0 is ignored.
- Register file: combinational read, write on `clk`. A write in xWB is visible to the next DECODE.
- Reset mid-access aborts the access. No write completes unless `mem_ready` was sampled before reset.

## Configuration
- `MC_LINK_EN` defined: jal and jr are implemented as above.
- `MC_LINK_EN` undefined: opcode 0x03 and funct 0x08 decode as unsupported and enter HALT. The jal writeback path and the jr PC source are absent.

## Structure
- Package `mc_pkg`:
  - state enum (FETCH, DECODE, EXEC, MEM, RWB, MWB, HALT);
  - opcode and funct constants;
  - ALU operation codes;
  - `REG_RA`=31.
- Sub-module `mc_regfile`: 32×32, 2 read / 1 write, asynchronous reset, $0 hardwired to 0.
- The ALU and sign/zero extension stay inline.

## Test plan
- Reset with 0-wait memory → first `mem_addr`=0x3000. `ori $1,$0,0x1234` gives `wb_data`=0x1234 on $1 in cycle 4, with `retire` that cycle.
- `lui $2,0x8000`; `addu $3,$2,$2` → $3=0 (wrap). `subu $4,$0,$1` → 0xFFFF_EDCC.
- `sw $1,8($0)` then `lw $5,8($0)` with `mem_ready` delayed 3 cycles on every access → write seen at address 8 with data 0x1234. $5=0x1234. lw takes 5+6 cycles.
- beq taken (offset -1) → PC returns to the beq address. beq not taken → PC+4. Each takes 3 cycles.
- jal at 0x3010 → $31=0x3014, PC=target. jr $31 → PC=0x3014. Without `MC_LINK_EN` → `halt`=1 and no further `mem_req`.
- Assert `rst` mid-MEM of a sw with `mem_ready` low → no write occurs, PC=0x3000, `mem_req`=0 immediately.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared state, opcode/funct, and ALU encodings for the multi-cycle MIPS-subset core.
package mc_pkg;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXEC,
        MEM,
        RWB,
        MWB,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_OR,
        ALU_PASSB
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [4:0] REG_RA   = 5'd31;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32x32 register file: two combinational read ports, one clocked write port, $0 reads as zero.
module mc_regfile
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  ra_addr,
    input  logic [4:0]  rb_addr,
    output logic [31:0] ra_data,
    output logic [31:0] rb_data,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // Writes to $0 are accepted on the port but never stored.
    always_comb begin
        regs_d = regs_q;
        if (we && waddr != 5'd0) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign ra_data = (ra_addr == 5'd0) ? 32'h0 : regs_q[ra_addr];
    assign rb_data = (rb_addr == 5'd0) ? 32'h0 : regs_q[rb_addr];

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-subset core with integrated controller and a single ready-handshake memory port.
// Define MC_LINK_EN to implement jal/jr; otherwise they decode as unsupported and halt the core.
module mc_datapath
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic [31:0]       pc,
    output logic [31:0]       instruction,
    output logic              retire,
    output logic              halt,
    output logic              wb_en,
    output logic [4:0]        wb_addr,
    output logic [31:0]       wb_data
);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_out_q, alu_out_d;
    logic [31:0] mdr_q, mdr_d;

    logic [31:0] rf_a, rf_b;
    logic        req_c, we_c;
    logic [31:0] addr_c;
    alu_op_t     alu_op;
    logic [31:0] alu_a, alu_b, alu_result;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] imm_sext;
    logic        is_rtype, is_addu, is_subu, is_jr, is_jal, is_j;
    logic        is_ori, is_lui, is_lw, is_sw, is_beq, supported;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign funct    = ir_q[5:0];
    assign imm      = ir_q[15:0];
    assign imm_sext = sext16(imm);

    assign is_rtype = (opcode == OP_RTYPE);
    assign is_addu  = is_rtype && (funct == FN_ADDU);
    assign is_subu  = is_rtype && (funct == FN_SUBU);
    assign is_j     = (opcode == OP_J);
    assign is_ori   = (opcode == OP_ORI);
    assign is_lui   = (opcode == OP_LUI);
    assign is_lw    = (opcode == OP_LW);
    assign is_sw    = (opcode == OP_SW);
    assign is_beq   = (opcode == OP_BEQ);
`ifdef MC_LINK_EN
    assign is_jr    = is_rtype && (funct == FN_JR);
    assign is_jal   = (opcode == OP_JAL);
`else
    assign is_jr    = 1'b0;
    assign is_jal   = 1'b0;
`endif
    assign supported = is_addu | is_subu | is_jr | is_j | is_jal | is_ori | is_lui
                     | is_lw | is_sw | is_beq;

    mc_regfile u_regfile (
        .clk     (clk),
        .rst     (rst),
        .ra_addr (rs),
        .rb_addr (rt),
        .ra_data (rf_a),
        .rb_data (rf_b),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    // The single ALU computes PC+4 in FETCH and the branch target in DECODE.
    always_comb begin
        alu_op = ALU_ADD;
        alu_a  = pc_q;
        alu_b  = 32'd4;
        if (state_q == DECODE) begin
            alu_b = imm_sext << 2;
        end else if (state_q == EXEC) begin
            alu_a = a_q;
            if (is_subu || is_beq) begin
                alu_op = ALU_SUB;
                alu_b  = b_q;
            end else if (is_addu) begin
                alu_b  = b_q;
            end else if (is_ori) begin
                alu_op = ALU_OR;
                alu_b  = {16'h0, imm};
            end else if (is_lui) begin
                alu_op = ALU_PASSB;
                alu_b  = {imm, 16'h0};
            end else begin
                alu_b  = imm_sext;
            end
        end
        case (alu_op)
            ALU_ADD:   alu_result = alu_a + alu_b;
            ALU_SUB:   alu_result = alu_a - alu_b;
            ALU_OR:    alu_result = alu_a | alu_b;
            default:   alu_result = alu_b;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        mdr_d     = mdr_q;
        req_c     = 1'b0;
        we_c      = 1'b0;
        addr_c    = pc_q;
        retire    = 1'b0;
        wb_en     = 1'b0;
        wb_addr   = 5'd0;
        wb_data   = 32'h0;
        case (state_q)
            FETCH: begin
                req_c = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = alu_result;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                a_d       = rf_a;
                b_d       = rf_b;
                alu_out_d = alu_result;
                if (!supported) begin
                    retire  = 1'b1;
                    state_d = HALT;
                end else if (is_j || is_jal) begin
                    pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                    retire  = 1'b1;
                    state_d = FETCH;
`ifdef MC_LINK_EN
                    if (is_jal) begin
                        wb_en   = 1'b1;
                        wb_addr = REG_RA;
                        wb_data = pc_q;
                    end
`endif
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_beq) begin
                    if (alu_result == 32'h0) begin
                        pc_d = alu_out_q;
                    end
                    retire  = 1'b1;
                    state_d = FETCH;
`ifdef MC_LINK_EN
                end else if (is_jr) begin
                    pc_d    = a_q;
                    retire  = 1'b1;
                    state_d = FETCH;
`endif
                end else if (is_lw || is_sw) begin
                    alu_out_d = alu_result;
                    state_d   = MEM;
                end else begin
                    alu_out_d = alu_result;
                    state_d   = RWB;
                end
            end
            MEM: begin
                req_c  = 1'b1;
                we_c   = is_sw;
                addr_c = alu_out_q;
                if (mem_ready) begin
                    if (is_sw) begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        mdr_d   = mem_rdata;
                        state_d = MWB;
                    end
                end
            end
            RWB: begin
                wb_en   = 1'b1;
                wb_addr = is_rtype ? rd : rt;
                wb_data = alu_out_q;
                retire  = 1'b1;
                state_d = FETCH;
            end
            MWB: begin
                wb_en   = 1'b1;
                wb_addr = rt;
                wb_data = mdr_q;
                retire  = 1'b1;
                state_d = FETCH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_out_q <= '0;
            mdr_q     <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            mdr_q     <= mdr_d;
        end
    end

    // Gating with rst drops the request the instant reset rises, aborting any access in flight.
    assign mem_req     = req_c & ~rst;
    assign mem_we      = we_c & mem_req;
    assign mem_addr    = mem_req ? {addr_c[ADDR_W-1:2], 2'b00} : '0;
    assign mem_wdata   = mem_we ? b_q : 32'h0;
    assign pc          = pc_q;
    assign instruction = ir_q;
    assign halt        = (state_q == HALT);

endmodule
